// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone B4 pipelined arbiter, round-robin grant held for the whole bus cycle.
// Latency: grant 1 cycle after cyc is first seen from IDLE; all datapath and response signals are combinational pass-through.
// Backpressure: non-granted master sees stall=1; granted master sees slave stall. Optional WB_ARBITER_TIMEOUT_EN adds the ack-timeout abort.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    // master 0
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic [31:0] o_m0_data,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    // master 1
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic [31:0] o_m1_data,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    // slave
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic [31:0] i_s_data,
    input  logic        i_s_stall,
    input  logic        i_s_ack
);

    // Timeout is held in a 16-bit counter; anything outside 2..65535 cannot be honoured.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;       // master served most recently; the other one wins a tie
    logic [4:0] out_q, out_d;         // requests accepted by the slave but not yet acked
    logic       grant0, grant1, granted;
    logic       grant_chg;
    logic       s_accept;
    logic       s_ack_seen;

    assign grant0    = (state_q == GRANT0);
    assign grant1    = (state_q == GRANT1);
    assign granted   = grant0 | grant1;
    assign grant_chg = (state_d != state_q);

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_q, tmo_d;
    logic        abort_first_q;
    logic        tmo_hit;

    // The counter would reach TIMEOUT_CYCLES on this edge: abort instead of counting on.
    assign tmo_hit = granted && (out_q != 5'd0) && !i_s_ack && (tmo_q == TMO_LAST);
`endif

    // Next grant: round-robin tie break from IDLE, direct handover when the owner releases cyc.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (i_m0_cyc) begin
                    state_d = GRANT0;
                end else if (i_m1_cyc) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!i_m0_cyc) begin
                    state_d = i_m1_cyc ? GRANT1 : IDLE;
                end
`ifdef WB_ARBITER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ABORT;
                end
`endif
            end
            GRANT1: begin
                if (!i_m1_cyc) begin
                    state_d = i_m0_cyc ? GRANT0 : IDLE;
                end
`ifdef WB_ARBITER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ABORT;
                end
`endif
            end
            ABORT: begin
`ifdef WB_ARBITER_TIMEOUT_EN
                // Stay parked until the aborted master gives up its cycle.
                if (!(last_q ? i_m1_cyc : i_m0_cyc)) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Record which master was served, updated on entry to its grant state.
    always_comb begin
        last_d = last_q;
        if (state_d == GRANT0 && state_q != GRANT0) begin
            last_d = 1'b0;
        end else if (state_d == GRANT1 && state_q != GRANT1) begin
            last_d = 1'b1;
        end
    end

    assign s_accept   = o_s_stb & ~i_s_stall;
    assign s_ack_seen = granted & i_s_ack;

    // Outstanding-request count: saturating up, non-underflowing down, reset on every grant change.
    always_comb begin
        out_d = out_q;
        if (grant_chg) begin
            out_d = 5'd0;
        end else if (s_accept && !s_ack_seen) begin
            if (out_q != 5'd31) begin
                out_d = out_q + 5'd1;
            end
        end else if (!s_accept && s_ack_seen) begin
            if (out_q != 5'd0) begin
                out_d = out_q - 5'd1;
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            out_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            out_q   <= out_d;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    // Ack-wait counter: runs only while something is outstanding and unanswered.
    always_comb begin
        tmo_d = tmo_q;
        if (grant_chg || i_s_ack) begin
            tmo_d = 16'd0;
        end else if (granted && out_q != 5'd0) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Timeout counter and the one-cycle marker for the first ABORT cycle.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            tmo_q         <= 16'd0;
            abort_first_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            abort_first_q <= (state_d == ABORT) && (state_q != ABORT);
        end
    end

    assign o_m0_err = (state_q == ABORT) && abort_first_q && !last_q;
    assign o_m1_err = (state_q == ABORT) && abort_first_q &&  last_q;
`else
    assign o_m0_err = 1'b0;
    assign o_m1_err = 1'b0;
`endif

    // Slave request path: owner's control, m0's payload whenever m1 does not own the bus.
    assign o_s_cyc  = grant0 ? i_m0_cyc : (grant1 ? i_m1_cyc : 1'b0);
    assign o_s_stb  = grant0 ? (i_m0_cyc & i_m0_stb) : (grant1 ? (i_m1_cyc & i_m1_stb) : 1'b0);
    assign o_s_we   = grant1 ? i_m1_we   : i_m0_we;
    assign o_s_addr = grant1 ? i_m1_addr : i_m0_addr;
    assign o_s_data = grant1 ? i_m1_data : i_m0_data;

    // Response path: acks only reach an owner that still holds cyc; everything else is dropped.
    assign o_m0_data  = i_s_data;
    assign o_m1_data  = i_s_data;
    assign o_m0_stall = grant0 ? i_s_stall : 1'b1;
    assign o_m1_stall = grant1 ? i_s_stall : 1'b1;
    assign o_m0_ack   = grant0 & i_m0_cyc & i_s_ack;
    assign o_m1_ack   = grant1 & i_m1_cyc & i_s_ack;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed bus cycles; expected slave requests and master responses
// are queued by the stimulus and checked by a separate negedge monitor.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_wdat, s_rdat;
    logic        s_stall, s_ack;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
        .i_wb_clk  (clk),     .i_wb_rst_n(rst_n),
        .i_m0_cyc  (m0_cyc),  .i_m0_stb  (m0_stb),  .i_m0_we (m0_we),
        .i_m0_addr (m0_addr), .i_m0_data (m0_wdat), .o_m0_data(m0_rdat),
        .o_m0_stall(m0_stall),.o_m0_ack  (m0_ack),  .o_m0_err(m0_err),
        .i_m1_cyc  (m1_cyc),  .i_m1_stb  (m1_stb),  .i_m1_we (m1_we),
        .i_m1_addr (m1_addr), .i_m1_data (m1_wdat), .o_m1_data(m1_rdat),
        .o_m1_stall(m1_stall),.o_m1_ack  (m1_ack),  .o_m1_err(m1_err),
        .o_s_cyc   (s_cyc),   .o_s_stb   (s_stb),   .o_s_we  (s_we),
        .o_s_addr  (s_addr),  .o_s_data  (s_wdat),  .i_s_data(s_rdat),
        .i_s_stall (s_stall), .i_s_ack   (s_ack)
    );

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} req_t;
    typedef struct packed {logic who; logic err; logic [31:0] data;} rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.we = we; r.addr = a; r.data = d;
        req_q.push_back(r);
    endtask

    task automatic exp_rsp(input logic who, input logic err, input logic [31:0] d);
        rsp_t r;
        r.who = who; r.err = err; r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic got_rsp(input logic who, input logic err, input logic [31:0] d);
        rsp_t e;
        if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: master %0d err=%0b data %h at %0t, none expected", who, err, d, $time);
        end else begin
            e = rsp_q.pop_front();
            chk("rsp_master", {31'd0, who}, {31'd0, e.who});
            chk("rsp_err", {31'd0, err}, {31'd0, e.err});
            chk("rsp_data", d, e.data);
        end
    endtask

    // Monitor: every accepted slave request and every master ack/err is matched against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (s_stb && !s_stall) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: addr %h data %h at %0t, none expected", s_addr, s_wdat, $time);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    chk("req_we", {31'd0, s_we}, {31'd0, e.we});
                    chk("req_addr", s_addr, e.addr);
                    chk("req_data", s_wdat, e.data);
                end
            end
            if (m0_ack || m0_err) got_rsp(1'b0, m0_err, m0_rdat);
            if (m1_ack || m1_err) got_rsp(1'b1, m1_err, m1_rdat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int who, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
        if (who == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = a; m0_wdat = d;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = a; m1_wdat = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        s_stall = 1'b0; s_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int k;
        s_rdat = 32'h1234_5678;
        rst_n  = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        s_stall = 1'b0; s_ack = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_s_stb", {31'd0, s_stb}, 32'd0);
        chk("rst_m0_stall", {31'd0, m0_stall}, 32'd1);
        chk("rst_m1_stall", {31'd0, m1_stall}, 32'd1);
        chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rst_m0_err", {31'd0, m0_err}, 32'd0);
        chk("rst_m0_data", m0_rdat, 32'h1234_5678);
        chk("rst_m1_data", m1_rdat, 32'h1234_5678);
        tick(); tick();
        rst_n = 1'b1;

        // ---- T1: single m0 write, ack two cycles after acceptance ----
        drv(0, 1, 1, 1, 32'h0, 32'h41);
        @(negedge clk);
        chk("t1_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("t1_idle_m0_stall", {31'd0, m0_stall}, 32'd1);
        exp_req(1'b1, 32'h0, 32'h41);
        tick();
        @(negedge clk);
        chk("t1_s_cyc", {31'd0, s_cyc}, 32'd1);
        chk("t1_s_data", s_wdat, 32'h41);
        chk("t1_m0_stall", {31'd0, m0_stall}, 32'd0);
        chk("t1_m1_stall_a", {31'd0, m1_stall}, 32'd1);
        tick();
        drv(0, 1, 0, 1, 32'h0, 32'h41);
        @(negedge clk);
        chk("t1_m1_stall_b", {31'd0, m1_stall}, 32'd1);
        tick();
        s_ack = 1'b1; s_rdat = 32'hDEAD_0001;
        exp_rsp(1'b0, 1'b0, 32'hDEAD_0001);
        @(negedge clk);
        chk("t1_m1_stall_c", {31'd0, m1_stall}, 32'd1);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("t1_ack_single", {31'd0, m0_ack}, 32'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        s_ack = 1'b1;
        @(negedge clk);
        chk("t1_drop_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("t1_drop_no_ack", {31'd0, m0_ack}, 32'd0);
        tick();
        @(negedge clk);
        chk("t1_after_no_ack0", {31'd0, m0_ack}, 32'd0);
        chk("t1_after_no_ack1", {31'd0, m1_ack}, 32'd0);
        tick();
        s_ack = 1'b0;

        // ---- T2: simultaneous request, round-robin alternation ----
        do_reset();
        drv(0, 1, 1, 1, 32'h100, 32'hA0);
        drv(1, 1, 1, 1, 32'h200, 32'hB1);
        @(negedge clk);
        chk("t2_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h100, 32'hA0);
        tick();
        @(negedge clk);
        chk("t2_g0_addr", s_addr, 32'h100);
        chk("t2_g0_m1_stall", {31'd0, m1_stall}, 32'd1);
        tick();
        drv(0, 1, 0, 1, 32'h100, 32'hA0);
        s_ack = 1'b1; s_rdat = 32'h0000_0A00;
        exp_rsp(1'b0, 1'b0, 32'h0000_0A00);
        tick();
        s_ack = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_m0_rel_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h200, 32'hB1);
        tick();
        @(negedge clk);
        chk("t2_g1_addr", s_addr, 32'h200);
        chk("t2_g1_m0_stall", {31'd0, m0_stall}, 32'd1);
        tick();
        drv(1, 1, 0, 1, 32'h200, 32'hB1);
        drv(0, 1, 1, 1, 32'h104, 32'hA4);
        s_ack = 1'b1; s_rdat = 32'h0000_0B00;
        exp_rsp(1'b1, 1'b0, 32'h0000_0B00);
        tick();
        s_ack = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_m1_rel_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h104, 32'hA4);
        tick();
        @(negedge clk);
        chk("t2_g0b_addr", s_addr, 32'h104);
        tick();
        drv(0, 1, 0, 1, 32'h104, 32'hA4);
        s_ack = 1'b1; s_rdat = 32'h0000_0A04;
        exp_rsp(1'b0, 1'b0, 32'h0000_0A04);
        tick();
        s_ack = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();

        // ---- T3: m1 pipelined read burst with alternating slave stall, m0 waiting ----
        drv(0, 1, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 32'h300, 32'h0);
        @(negedge clk);
        chk("t3_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        tick();
        sent = 0;
        k = 0;
        while (sent < 4 && k < 16) begin
            s_stall = (k % 2 == 0);
            drv(1, 1, 1, 0, 32'h300 + 32'(4 * sent), 32'h0);
            if (!s_stall) exp_req(1'b0, 32'h300 + 32'(4 * sent), 32'h0);
            @(negedge clk);
            chk("t3_m0_stall", {31'd0, m0_stall}, 32'd1);
            chk("t3_m1_stall", {31'd0, m1_stall}, {31'd0, s_stall});
            tick();
            if (!s_stall) sent++;
            k++;
        end
        drv(1, 1, 0, 0, 32'h0, 32'h0);
        s_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'b1; s_rdat = 32'h5000 + 32'(i);
            exp_rsp(1'b1, 1'b0, 32'h5000 + 32'(i));
            @(negedge clk);
            chk("t3_ack_m0_stall", {31'd0, m0_stall}, 32'd1);
            tick();
        end
        s_ack = 1'b0;
        @(negedge clk);
        chk("t3_no_fifth_ack", {31'd0, m1_ack}, 32'd0);
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // ---- T4: spurious ack while IDLE ----
        s_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_idle_m0_ack", {31'd0, m0_ack}, 32'd0);
            chk("t4_idle_m1_ack", {31'd0, m1_ack}, 32'd0);
            tick();
        end
        s_ack = 1'b0;

        // ---- T5: reset in the middle of a GRANT1 cycle ----
        drv(1, 1, 1, 1, 32'h400, 32'hD0);
        s_stall = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_g1_s_cyc", {31'd0, s_cyc}, 32'd1);
        tick();
        drv(0, 1, 1, 1, 32'h500, 32'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("t5_async_m1_stall", {31'd0, m1_stall}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        s_stall = 1'b0;
        @(negedge clk);
        chk("t5_post_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h500, 32'hE0);
        tick();
        @(negedge clk);
        chk("t5_m0_wins_addr", s_addr, 32'h500);
        chk("t5_m1_stall", {31'd0, m1_stall}, 32'd1);
        tick();
        drv(0, 1, 0, 1, 32'h500, 32'hE0);
        s_ack = 1'b1; s_rdat = 32'h0000_0E00;
        exp_rsp(1'b0, 1'b0, 32'h0000_0E00);
        tick();
        s_ack = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_m0_rel_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h400, 32'hD0);
        tick();
        @(negedge clk);
        chk("t5_g1_addr", s_addr, 32'h400);
        tick();
        drv(1, 1, 0, 1, 32'h400, 32'hD0);
        s_ack = 1'b1; s_rdat = 32'h0000_0D00;
        exp_rsp(1'b1, 1'b0, 32'h0000_0D00);
        tick();
        s_ack = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        tick();

        // ---- T6: slave never acks ----
        drv(0, 1, 1, 1, 32'h600, 32'h66);
        exp_req(1'b1, 32'h600, 32'h66);
        tick();
        @(negedge clk);
        chk("t6_g0_s_cyc", {31'd0, s_cyc}, 32'd1);
        tick();
        drv(0, 1, 0, 1, 32'h600, 32'h66);
`ifdef WB_ARBITER_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t6_err_early", {31'd0, m0_err}, 32'd0);
            chk("t6_wait_s_cyc", {31'd0, s_cyc}, 32'd1);
            tick();
        end
        exp_rsp(1'b0, 1'b1, s_rdat);
        @(negedge clk);
        chk("t6_abort_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("t6_abort_m0_stall", {31'd0, m0_stall}, 32'd1);
        tick();
        @(negedge clk);
        chk("t6_err_once", {31'd0, m0_err}, 32'd0);
        chk("t6_abort_s_cyc2", {31'd0, s_cyc}, 32'd0);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        drv(0, 1, 1, 1, 32'h700, 32'h77);
        @(negedge clk);
        chk("t6_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
        exp_req(1'b1, 32'h700, 32'h77);
        tick();
        @(negedge clk);
        chk("t6_regrant_s_cyc", {31'd0, s_cyc}, 32'd1);
        tick();
        drv(0, 1, 0, 1, 32'h700, 32'h77);
        s_ack = 1'b1; s_rdat = 32'h0000_0700;
        exp_rsp(1'b0, 1'b0, 32'h0000_0700);
        tick();
        s_ack = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_held_s_cyc", {31'd0, s_cyc}, 32'd1);
            chk("t6_no_err", {31'd0, m0_err}, 32'd0);
            chk("t6_m0_stall", {31'd0, m0_stall}, 32'd0);
            tick();
        end
        s_ack = 1'b1; s_rdat = 32'h0000_0600;
        exp_rsp(1'b0, 1'b0, 32'h0000_0600);
        tick();
        s_ack = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
`endif

        tick();
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
